fpu16_accumulator: RTL and testbench
====================================

# fpu16_accumulator

Downstream consumer of the FP16 multiplier: accumulates a stream of FP16 products into one FP16 sum per group, for dot products and MAC chains. Accepts one term per valid/ready handshake, adds it to an internal accumulator through a multi-cycle align/add/normalize FSM, and presents the group sum when the term tagged `in_last` has been added. Arithmetic truncates (round toward zero) and flushes subnormals, matching the multiplier's number handling.

## Interface
- `CNT_W`, default 8: width of the term counter.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  term valid.
- `in_ready`  out  1  high only in IDLE.
- `in_data`  in  16  FP16 term.
- `in_last`  in  1  term closes the group; sampled with `in_data`.
- `out_valid`  out  1  group sum valid; high only in OUT.
- `out_ready`  in  1  downstream accepts the sum.
- `out_data`  out  16  FP16 group sum.
- `out_flags`  out  3  sticky per group: [0] NaN produced or propagated, [1] overflow, [2] underflow.
- `out_count`  out  CNT_W  terms in the group, saturating at 2^CNT_W-1.

## Operation
- States: IDLE, ALIGN, ADD, NORM, OUT.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`:
  - capture `in_data` and `in_last`;
  - increment count (saturating);
  - go to ALIGN.
- ALIGN:
  - Operands: x = acc, y = captured term.
  - Classify each operand by exponent e:
    - e==0 is zero; any mantissa is flushed.
    - e==31 with mant==0 is inf.
    - e==31 with mant!=0 is NaN.
  - Specials, in priority order; result is resolved here and NORM passes it through:
    - either operand NaN, or inf + inf of opposite sign: result 16'h7E00, set flag[0];
    - one operand inf: result is that inf;
    - y zero: result x;
    - x zero: result y.
  - Otherwise:
    - big/small chosen by comparing {exp,mant} (on a tie, x is big).
    - d = e_big − e_small.
    - mb = {1,mant_big,3'b000} (14 bits).
    - ms = {1,mant_small,3'b000} >> d, bits shifted out discarded; d≥14 gives ms=0.
- ADD:
  - Equal signs: s = mb+ms (15 bits). Signs differ: s = mb−ms.
  - Result sign = sign of big.
- NORM:
  - Same sign with s[14]=1: s>>=1, e=e_big+1.
  - Difference: s==0 gives +0 (16'h0000). Otherwise shift left by the leading-zero count so s[13]=1, with e=e_big−shift.
  - e≥31: result {sign,5'h1F,10'h0}, set flag[1].
  - e≤0: result {sign,15'h0}, set flag[2].
  - Else: result {sign,e[4:0],s[12:3]}; dropped LSBs are truncated.
  - Write result to acc. Go to OUT if the captured last bit is set, else IDLE.
- OUT:
  - `out_valid`=1; `out_data`=acc, `out_flags`, `out_count` held stable.
  - On `out_valid`&&`out_ready`: acc←16'h0000, flags←0, count←0; go to IDLE.
- Accumulator starts every group at +0, so the first term's result equals the term, with subnormals flushed to +0.
- A group of one term with `in_last`=1 is legal.

## Timing
- Reset, asynchronous: state IDLE, acc=0, flags=0, count=0. Outputs: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_flags`=0, `out_count`=0.
- Reset mid-operation abandons the group completely; no partial sum is emitted.
- Per term, with acceptance at edge E0: ALIGN after E0, ADD after E1, NORM after E2, and at E3 acc is updated and the state becomes IDLE or OUT.
  - Max throughput: 1 term per 4 cycles.
  - Last term: `out_valid` rises 3 cycles after its acceptance edge.
- `in_ready` is 0 in ALIGN/ADD/NORM/OUT. The upstream holds `in_data`/`in_last` while `in_valid`&&!`in_ready`.
- `out_valid` stays high and `out_data` stays stable until `out_ready`; no new term is taken while in OUT.
- The OUT→IDLE handshake cycle does not accept an input. The earliest next acceptance is the following edge.
- Flags are sticky within a group and cleared only by the output handshake or reset.

## Test plan
- Group 3C00 (1.0), then 4000 (2.0) with last → `out_data`=4200, flags=0, count=2, `out_valid` 3 cycles after the second acceptance.
- Group 3C00, then BC00 with last → `out_data`=0000, flags=0. Then group 0401, then 8400 with last → 0000, flag[2]=1.
- Group 7BFF, then 7BFF with last → 7C00, flag[1]=1. Then group 7C00, then FC00 with last → 7E00, flag[0]=1.
- Group 7E01, then 3C00 with last → 7E00, flag[0]=1. Single-term group 0200 (subnormal) with last → 0000, count=1.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 → `out_data` stable, `in_ready`=0 throughout; the next term is accepted 1 cycle after the handshake and the sum restarts from +0.
- Assert `rst_n`=0 during ADD of a 3-term group → all outputs are at reset values immediately. After release, group 3C00 with last → 3C00, count=1.

Source files
------------

// File: rtl/fpu16_accumulator.sv
// FP16 group accumulator: sums a stream of FP16 terms into one FP16 result per
// group using a four-step accept/align/add/normalize sequence. Arithmetic
// truncates toward zero and flushes subnormal operands and results to zero.
module fpu16_accumulator #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic [2:0]       out_flags,
   output logic [CNT_W-1:0] out_count
);

   localparam int unsigned FP_W  = 16;
   localparam int unsigned EXP_W = 5;
   localparam int unsigned MAN_W = 10;
   localparam int unsigned SIG_W = 14;
   localparam int unsigned SUM_W = 15;
   localparam int unsigned EXT_W = 7;
   localparam int unsigned LZ_W  = 4;
   localparam int          EXP_INF = 31;

   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

   state_t               state_q;
   logic [FP_W-1:0]      acc_q;
   logic [2:0]           flags_q;
   logic [CNT_W-1:0]     count_q;
   logic [FP_W-1:0]      term_q;
   logic                 last_q;
   logic                 spec_q;
   logic [FP_W-1:0]      spec_res_q;
   logic                 sign_q;
   logic                 sub_q;
   logic [EXP_W-1:0]     e_big_q;
   logic [SIG_W-1:0]     mb_q;
   logic [SIG_W-1:0]     ms_q;
   logic [SUM_W-1:0]     sum_q;

   // Leading-zero count of a 14-bit significand (14 when all zero).
   function automatic logic [LZ_W-1:0] lzc14(input logic [SIG_W-1:0] v);
      lzc14 = LZ_W'(SIG_W);
      for (int i = 0; i < int'(SIG_W); i++) begin
         if (v[i]) lzc14 = LZ_W'(int'(SIG_W) - 1 - i);
      end
   endfunction

   // Operand fields: x is the running accumulator, y the captured term.
   logic                 x_sign, y_sign;
   logic [EXP_W-1:0]     x_exp, y_exp;
   logic [MAN_W-1:0]     x_man, y_man;
   logic                 x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;

   assign x_sign = acc_q[FP_W-1];
   assign y_sign = term_q[FP_W-1];
   assign x_exp  = acc_q[FP_W-2 -: EXP_W];
   assign y_exp  = term_q[FP_W-2 -: EXP_W];
   assign x_man  = acc_q[MAN_W-1:0];
   assign y_man  = term_q[MAN_W-1:0];
   assign x_zero = (x_exp == '0);
   assign y_zero = (y_exp == '0);
   assign x_inf  = (x_exp == '1) && (x_man == '0);
   assign y_inf  = (y_exp == '1) && (y_man == '0);
   assign x_nan  = (x_exp == '1) && (x_man != '0);
   assign y_nan  = (y_exp == '1) && (y_man != '0);

   logic                 al_spec, al_nan, al_sign, al_sub, x_big;
   logic [FP_W-1:0]      al_res;
   logic [EXP_W-1:0]     al_ebig, e_small, d;
   logic [MAN_W-1:0]     man_big, man_small;
   logic [SIG_W-1:0]     al_mb, al_ms;

   // Align step: resolve specials or pick big/small and right-shift the small significand.
   always_comb begin
      al_spec   = 1'b0;
      al_nan    = 1'b0;
      al_res    = '0;
      al_sign   = 1'b0;
      al_sub    = 1'b0;
      x_big     = 1'b0;
      al_ebig   = '0;
      e_small   = '0;
      man_big   = '0;
      man_small = '0;
      d         = '0;
      al_mb     = '0;
      al_ms     = '0;
      if (x_nan || y_nan || (x_inf && y_inf && (x_sign != y_sign))) begin
         al_spec = 1'b1;
         al_nan  = 1'b1;
         al_res  = 16'h7E00;
      end else if (x_inf) begin
         al_spec = 1'b1;
         al_res  = acc_q;
      end else if (y_inf) begin
         al_spec = 1'b1;
         al_res  = term_q;
      end else if (y_zero) begin
         al_spec = 1'b1;
         al_res  = acc_q;
      end else if (x_zero) begin
         al_spec = 1'b1;
         al_res  = term_q;
      end else begin
         x_big     = (acc_q[FP_W-2:0] >= term_q[FP_W-2:0]);
         al_sign   = x_big ? x_sign : y_sign;
         al_sub    = (x_sign != y_sign);
         al_ebig   = x_big ? x_exp : y_exp;
         e_small   = x_big ? y_exp : x_exp;
         man_big   = x_big ? x_man : y_man;
         man_small = x_big ? y_man : x_man;
         d         = al_ebig - e_small;
         al_mb     = {1'b1, man_big, 3'b000};
         al_ms     = (d >= EXP_W'(SIG_W)) ? '0 : (SIG_W'({1'b1, man_small, 3'b000}) >> d);
      end
   end

   logic [LZ_W-1:0]         lz;
   logic signed [EXT_W-1:0] nm_exp;
   logic [MAN_W-1:0]        nm_frac;
   logic [FP_W-1:0]         nm_res;
   logic                    nm_ovf, nm_unf;

   // Normalize step: renormalize the sum, detect overflow/underflow and pack the result.
   always_comb begin
      lz      = lzc14(sum_q[SIG_W-1:0]);
      nm_exp  = '0;
      nm_frac = '0;
      nm_res  = '0;
      nm_ovf  = 1'b0;
      nm_unf  = 1'b0;
      if (!sub_q && sum_q[SUM_W-1]) begin
         nm_exp  = EXT_W'(e_big_q) + EXT_W'(1);
         nm_frac = sum_q[SIG_W-1 -: MAN_W];
      end else if (!sub_q) begin
         nm_exp  = EXT_W'(e_big_q);
         nm_frac = sum_q[SIG_W-2 -: MAN_W];
      end else begin
         nm_exp  = EXT_W'(e_big_q) - EXT_W'(lz);
         nm_frac = MAN_W'((sum_q[SIG_W-2:0] << lz) >> 3);
      end
      if (spec_q) begin
         nm_res = spec_res_q;
      end else if (sub_q && (sum_q == '0)) begin
         nm_res = '0;
      end else if (nm_exp >= $signed(EXT_W'(EXP_INF))) begin
         nm_res = {sign_q, 5'h1F, 10'h000};
         nm_ovf = 1'b1;
      end else if (nm_exp <= $signed(EXT_W'(0))) begin
         nm_res = {sign_q, 15'h0000};
         nm_unf = 1'b1;
      end else begin
         nm_res = {sign_q, nm_exp[EXP_W-1:0], nm_frac};
      end
   end

   // Control FSM with datapath registers and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         acc_q      <= '0;
         flags_q    <= '0;
         count_q    <= '0;
         term_q     <= '0;
         last_q     <= 1'b0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         sign_q     <= 1'b0;
         sub_q      <= 1'b0;
         e_big_q    <= '0;
         mb_q       <= '0;
         ms_q       <= '0;
         sum_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  term_q   <= in_data;
                  last_q   <= in_last;
                  if (count_q != '1) count_q <= count_q + CNT_W'(1);
                  in_ready <= 1'b0;
                  state_q  <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               spec_q     <= al_spec;
               spec_res_q <= al_res;
               sign_q     <= al_sign;
               sub_q      <= al_sub;
               e_big_q    <= al_ebig;
               mb_q       <= al_mb;
               ms_q       <= al_ms;
               if (al_nan) flags_q[0] <= 1'b1;
               state_q    <= S_ADD;
            end
            S_ADD: begin
               sum_q   <= sub_q ? (SUM_W'(mb_q) - SUM_W'(ms_q)) : (SUM_W'(mb_q) + SUM_W'(ms_q));
               state_q <= S_NORM;
            end
            S_NORM: begin
               acc_q      <= nm_res;
               flags_q[1] <= flags_q[1] | nm_ovf;
               flags_q[2] <= flags_q[2] | nm_unf;
               if (last_q) begin
                  out_valid <= 1'b1;
                  state_q   <= S_OUT;
               end else begin
                  in_ready  <= 1'b1;
                  state_q   <= S_IDLE;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  acc_q     <= '0;
                  flags_q   <= '0;
                  count_q   <= '0;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_q   <= S_IDLE;
               end
            end
            default: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               state_q   <= S_IDLE;
            end
         endcase
      end
   end

   assign out_data  = acc_q;
   assign out_flags = flags_q;
   assign out_count = count_q;

endmodule

// File: tb/tb_fpu16_accumulator.sv
// Testbench for fpu16_accumulator: table of term groups plus hand-written
// latency, backpressure, saturation and mid-group reset sequences; expected
// group sums flow through a scoreboard queue checked at each output handshake.
module tb_fpu16_accumulator;

   localparam int unsigned CNT_W = 8;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_data;
   logic [2:0]       out_flags;
   logic [CNT_W-1:0] out_count;

   fpu16_accumulator #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags),
      .out_count (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] d;
      logic [2:0]  f;
      logic [7:0]  c;
   } exp_t;

   typedef struct {
      int          n;
      logic [15:0] t0;
      logic [15:0] t1;
      logic [15:0] t2;
      logic [15:0] exp_data;
      logic [2:0]  exp_flags;
      logic [7:0]  exp_count;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[15];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive point: just after the rising edge, once registered outputs have settled.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send_term(input logic [15:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      for (int k = 0; k < 64 && !in_ready; k++) step();
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: term %h not accepted within 64 cycles", d);
         in_valid = 1'b0;
         return;
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 100 && sb.size() != 0; k++) step();
      if (sb.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: %0d sums still pending", sb.size());
         sb.delete();
      end
   endtask

   function automatic vec_t mk(input int n, input logic [15:0] t0, input logic [15:0] t1,
                               input logic [15:0] t2, input logic [15:0] ed,
                               input logic [2:0] ef, input logic [7:0] ec);
      vec_t v;
      v.n = n; v.t0 = t0; v.t1 = t1; v.t2 = t2;
      v.exp_data = ed; v.exp_flags = ef; v.exp_count = ec;
      return v;
   endfunction

   // Scoreboard: compare each emitted sum against the oldest expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got %h with no sum pending", out_data);
         end else begin
            e = sb.pop_front();
            chk("sum_data",  32'(out_data),  32'(e.d));
            chk("sum_flags", 32'(out_flags), 32'(e.f));
            chk("sum_count", 32'(out_count), 32'(e.c));
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      vecs[0]  = mk(2, 16'h3C00, 16'h4000, 16'h0000, 16'h4200, 3'b000, 8'd2);
      vecs[1]  = mk(2, 16'h3C00, 16'hBC00, 16'h0000, 16'h0000, 3'b000, 8'd2);
      vecs[2]  = mk(2, 16'h0401, 16'h8400, 16'h0000, 16'h0000, 3'b100, 8'd2);
      vecs[3]  = mk(2, 16'h7BFF, 16'h7BFF, 16'h0000, 16'h7C00, 3'b010, 8'd2);
      vecs[4]  = mk(2, 16'h7C00, 16'hFC00, 16'h0000, 16'h7E00, 3'b001, 8'd2);
      vecs[5]  = mk(2, 16'h7E01, 16'h3C00, 16'h0000, 16'h7E00, 3'b001, 8'd2);
      vecs[6]  = mk(1, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 3'b000, 8'd1);
      vecs[7]  = mk(2, 16'h4000, 16'hBC00, 16'h0000, 16'h3C00, 3'b000, 8'd2);
      vecs[8]  = mk(2, 16'h3C00, 16'h1400, 16'h0000, 16'h3C01, 3'b000, 8'd2);
      vecs[9]  = mk(2, 16'h3C00, 16'h1000, 16'h0000, 16'h3C00, 3'b000, 8'd2);
      vecs[10] = mk(3, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4200, 3'b000, 8'd3);
      vecs[11] = mk(2, 16'hBC00, 16'hC000, 16'h0000, 16'hC200, 3'b000, 8'd2);
      vecs[12] = mk(2, 16'h3C00, 16'hFC00, 16'h0000, 16'hFC00, 3'b000, 8'd2);
      vecs[13] = mk(3, 16'h7BFF, 16'h7BFF, 16'h3C00, 16'h7C00, 3'b010, 8'd3);
      vecs[14] = mk(3, 16'h0401, 16'h8400, 16'h3C00, 16'h3C00, 3'b100, 8'd3);

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      in_last   = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'h0);
      chk("rst_out_flags", 32'(out_flags), 32'h0);
      chk("rst_out_count", 32'(out_count), 32'h0);
      rst_n = 1'b1;
      step();

      // Latency: out_valid rises three edges after the last term is accepted.
      send_term(16'h3C00, 1'b0);
      sb.push_back('{d: 16'h4200, f: 3'b000, c: 8'd2});
      send_term(16'h4000, 1'b1);
      chk("lat_align_valid", 32'(out_valid), 32'd0);
      chk("lat_align_ready", 32'(in_ready),  32'd0);
      step();
      chk("lat_add_valid",   32'(out_valid), 32'd0);
      step();
      chk("lat_norm_valid",  32'(out_valid), 32'd0);
      step();
      chk("lat_out_valid",   32'(out_valid), 32'd1);
      drain();

      // Table of groups.
      foreach (vecs[i]) begin
         sb.push_back('{d: vecs[i].exp_data, f: vecs[i].exp_flags, c: vecs[i].exp_count});
         send_term(vecs[i].t0, vecs[i].n == 1);
         if (vecs[i].n >= 2) send_term(vecs[i].t1, vecs[i].n == 2);
         if (vecs[i].n >= 3) send_term(vecs[i].t2, 1'b1);
      end
      drain();

      // Backpressure: sum held stable, no acceptance while OUT, restart from +0.
      out_ready = 1'b0;
      sb.push_back('{d: 16'h4200, f: 3'b000, c: 8'd2});
      send_term(16'h3C00, 1'b0);
      send_term(16'h4000, 1'b1);
      step();
      step();
      step();
      in_valid = 1'b1;
      in_data  = 16'h3C00;
      in_last  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_data",  32'(out_data),  32'h4200);
         chk("bp_in_ready",  32'(in_ready),  32'd0);
         step();
      end
      sb.push_back('{d: 16'h3C00, f: 3'b000, c: 8'd1});
      out_ready = 1'b1;
      step();
      chk("bp_post_hs_ready", 32'(in_ready),  32'd1);
      chk("bp_post_hs_valid", 32'(out_valid), 32'd0);
      step();
      in_valid = 1'b0;
      chk("bp_next_accepted", 32'(in_ready), 32'd0);
      drain();

      // Count saturation over a 300-term group.
      send_term(16'h3C00, 1'b0);
      for (int k = 0; k < 298; k++) send_term(16'h0000, 1'b0);
      sb.push_back('{d: 16'h3C00, f: 3'b000, c: 8'hFF});
      send_term(16'h0000, 1'b1);
      drain();

      // Reset during ADD of a 3-term group abandons it entirely.
      send_term(16'h3C00, 1'b0);
      send_term(16'h3C00, 1'b0);
      step();
      rst_n = 1'b0;
      #1;
      chk("mrst_in_ready",  32'(in_ready),  32'd1);
      chk("mrst_out_valid", 32'(out_valid), 32'd0);
      chk("mrst_out_data",  32'(out_data),  32'h0);
      chk("mrst_out_flags", 32'(out_flags), 32'h0);
      chk("mrst_out_count", 32'(out_count), 32'h0);
      step();
      step();
      rst_n = 1'b1;
      step();
      sb.push_back('{d: 16'h3C00, f: 3'b000, c: 8'd1});
      send_term(16'h3C00, 1'b1);
      drain();
      for (int k = 0; k < 10; k++) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
